// File: rtl/pk_pkg.sv
// -----------------------------------------------------------------------------
// pk_pkg
// Shared definitions for the password-encryption command front end
// (pk_cmd_loader and pk_tx_serializer).
//   - Opcode bytes understood by the loader.
//   - Block/byte/address widths of the Hw_wrapper interface.
//   - Loader state encoding.
//   - put_byte(): writes one byte of a 128-bit field, MSB-first byte order.
// -----------------------------------------------------------------------------
package pk_pkg;

    localparam int BLK_W  = 128;
    localparam int BYTE_W = 8;
    localparam int ADDR_W = 4;
    localparam int NBYTES = BLK_W / BYTE_W;

    localparam logic [BYTE_W-1:0] OP_SET_KEY   = 8'h01;
    localparam logic [BYTE_W-1:0] OP_ENCRYPT   = 8'h02;
    localparam logic [BYTE_W-1:0] OP_SET_MAX   = 8'h03;
    localparam logic [BYTE_W-1:0] TIMEOUT_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_KEY    = 3'd1,
        ST_RX_ACCT   = 3'd2,
        ST_RX_PWD    = 3'd3,
        ST_RX_MAX    = 3'd4,
        ST_START     = 3'd5,
        ST_WAIT_DONE = 3'd6,
        ST_TX        = 3'd7
    } state_e;

    // Byte idx 0 lands in [127:120], byte idx 15 in [7:0].
    function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0]  blk,
                                                  input logic [3:0]        idx,
                                                  input logic [BYTE_W-1:0] b);
        logic [BLK_W-1:0] r;
        int               pos;
        r   = blk;
        pos = (NBYTES - 1 - int'(idx)) * BYTE_W;
        r[pos +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/pk_tx_serializer.sv
// -----------------------------------------------------------------------------
// pk_tx_serializer
// Loads a 128-bit block in parallel and shifts it out one byte per valid/ready
// handshake, most significant byte first. A "single" load emits just the
// timeout marker byte instead of the full block.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              load request (ignored bytes in flight are overwritten)
//   load_data[127:0]  block to send
//   load_single       send only TIMEOUT_BYTE
//   tx_data[7:0]      current byte
//   tx_valid          a byte is pending
//   tx_ready          consumer accepts the byte
//   busy              bytes still pending
//   last              the pending byte is the final one
// -----------------------------------------------------------------------------
module pk_tx_serializer
    import pk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic              load_single,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              last
);

    logic [BLK_W-1:0] shreg_q, shreg_d;
    logic [4:0]       remain_q, remain_d;

    always_comb begin
        shreg_d  = shreg_q;
        remain_d = remain_q;
        if (load) begin
            if (load_single) begin
                shreg_d  = {TIMEOUT_BYTE, {(BLK_W-BYTE_W){1'b0}}};
                remain_d = 5'd1;
            end else begin
                shreg_d  = load_data;
                remain_d = 5'(NBYTES);
            end
        end else if ((remain_q != 5'd0) && tx_ready) begin
            shreg_d  = {shreg_q[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            remain_d = remain_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            remain_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            remain_q <= remain_d;
        end
    end

    assign tx_data  = shreg_q[BLK_W-1 -: BYTE_W];
    assign tx_valid = (remain_q != 5'd0);
    assign busy     = (remain_q != 5'd0);
    assign last     = (remain_q == 5'd1);

endmodule

// File: rtl/pk_cmd_loader.sv
// -----------------------------------------------------------------------------
// pk_cmd_loader
// Byte-stream command front end for Hw_wrapper. Frames are an opcode byte
// followed by a payload, multi-byte fields MSB first:
//   0x01 SET_KEY  16 B master_key (marks the key valid)
//   0x02 ENCRYPT  16 B account, 16 B password, then go / wait done / 16 B result
//   0x03 SET_MAX  1 B, low nibble -> max_address
// Unknown opcodes and ENCRYPT without a loaded key set the sticky err flag.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   command byte stream in
//   tx_data/tx_valid/tx_ready   result byte stream out
//   master_key/account/password/max_address   fields to Hw_wrapper
//   go                          one-cycle start pulse
//   done, password_enc          completion and result from Hw_wrapper
//   err                         sticky error, cleared by rst only
// Configuration macro PK_DONE_TIMEOUT_EN: adds a done watchdog of
// TIMEOUT_CYCLES cycles; on expiry err is set and the single byte 0xEE is
// returned instead of the result.
// -----------------------------------------------------------------------------
module pk_cmd_loader
    import pk_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [BLK_W-1:0]  master_key,
    output logic [BLK_W-1:0]  account,
    output logic [BLK_W-1:0]  password,
    output logic [ADDR_W-1:0] max_address,
    output logic              go,
    input  logic              done,
    input  logic [BLK_W-1:0]  password_enc,
    output logic              err
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BLK_W-1:0]  key_q, key_d;
    logic [BLK_W-1:0]  acct_q, acct_d;
    logic [BLK_W-1:0]  pwd_q, pwd_d;
    logic [ADDR_W-1:0] max_q, max_d;
    logic              key_valid_q, key_valid_d;
    logic              err_q, err_d;

    logic              rx_ready_int;
    logic              rx_fire;
    logic              cnt_last;
    logic              ser_load;
    logic              ser_single;
    logic              ser_busy;
    logic              ser_last;
    logic              timeout_hit;

`ifdef PK_DONE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wcnt_q, wcnt_d;

    // Counts cycles spent in WAIT_DONE; zero on entry because it is held
    // clear in every other state.
    always_comb begin
        wcnt_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == ST_WAIT_DONE) begin
            wcnt_d      = wcnt_q + TW'(1);
            timeout_hit = !done && (wcnt_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    assign rx_ready_int = (state_q == ST_IDLE)    || (state_q == ST_RX_KEY) ||
                          (state_q == ST_RX_ACCT) || (state_q == ST_RX_PWD) ||
                          (state_q == ST_RX_MAX);
    assign rx_fire      = rx_valid && rx_ready_int;
    assign cnt_last     = (cnt_q == 4'hF);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        acct_d      = acct_q;
        pwd_d       = pwd_q;
        max_d       = max_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        ser_load    = 1'b0;
        ser_single  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    cnt_d = 4'h0;
                    case (rx_data)
                        OP_SET_KEY: state_d = ST_RX_KEY;
                        OP_ENCRYPT: state_d = ST_RX_ACCT;
                        OP_SET_MAX: state_d = ST_RX_MAX;
                        default:    err_d   = 1'b1;
                    endcase
                end
            end

            ST_RX_KEY: begin
                if (rx_fire) begin
                    key_d = put_byte(key_q, cnt_q, rx_data);
                    cnt_d = cnt_q + 4'h1;
                    if (cnt_last) begin
                        key_valid_d = 1'b1;
                        cnt_d       = 4'h0;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_RX_ACCT: begin
                if (rx_fire) begin
                    acct_d = put_byte(acct_q, cnt_q, rx_data);
                    cnt_d  = cnt_q + 4'h1;
                    if (cnt_last) begin
                        cnt_d   = 4'h0;
                        state_d = ST_RX_PWD;
                    end
                end
            end

            ST_RX_PWD: begin
                if (rx_fire) begin
                    pwd_d = put_byte(pwd_q, cnt_q, rx_data);
                    cnt_d = cnt_q + 4'h1;
                    if (cnt_last) begin
                        cnt_d = 4'h0;
                        // Without a key the whole frame is still consumed so the
                        // host stays in sync, but nothing is started.
                        if (key_valid_q) begin
                            state_d = ST_START;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_RX_MAX: begin
                if (rx_fire) begin
                    max_d   = rx_data[ADDR_W-1:0];
                    cnt_d   = 4'h0;
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (done) begin
                    ser_load = 1'b1;
                    state_d  = ST_TX;
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    ser_load   = 1'b1;
                    ser_single = 1'b1;
                    state_d    = ST_TX;
                end
            end

            ST_TX: begin
                // !ser_busy is a guard only; normal exit is the final handshake.
                if (!ser_busy || (ser_last && tx_ready)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            acct_q      <= '0;
            pwd_q       <= '0;
            max_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            acct_q      <= acct_d;
            pwd_q       <= pwd_d;
            max_q       <= max_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end

    pk_tx_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .load_data   (password_enc),
        .load_single (ser_single),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (ser_busy),
        .last        (ser_last)
    );

    assign rx_ready    = rx_ready_int;
    assign go          = (state_q == ST_START);
    assign master_key  = key_q;
    assign account     = acct_q;
    assign password    = pwd_q;
    assign max_address = max_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pk_cmd_loader.sv
module tb_pk_cmd_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] master_key;
    logic [127:0] account;
    logic [127:0] password;
    logic [3:0]   max_address;
    logic         go;
    logic         done;
    logic [127:0] password_enc;
    logic         err;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q[$];
    int         go_cnt     = 0;
    int         stall_viol = 0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_byte = 8'h00;

    localparam logic [127:0] KEY  = 128'hf256847daea39da5d870adf569712360;
    localparam logic [127:0] PWD  = 128'hf256847daaa39da5d870adf569712360;
    localparam logic [127:0] ENC1 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ENC2 = 128'h00112233445566778899aabbccddeeff;

    pk_cmd_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .master_key   (master_key),
        .account      (account),
        .password     (password),
        .max_address  (max_address),
        .go           (go),
        .done         (done),
        .password_enc (password_enc),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so negedge sees what the next posedge sees.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (stall_pend && (!tx_valid || tx_data !== stall_byte)) stall_viol <= stall_viol + 1;
        stall_pend <= tx_valid && !tx_ready;
        stall_byte <= tx_data;
        if (go) go_cnt <= go_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int guard = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = (guard < 100);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] v, inout int acc);
        bit ok;
        for (int i = 0; i < 16; i++) begin
            send_byte(v[127-8*i -: 8], ok);
            if (ok) acc++;
        end
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        done         = 1'b0;
        password_enc = '0;
        tx_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic collect(input logic [127:0] exp, input int n, input bit toggle,
                           input int base, input string name);
        int guard = 0;
        while ((rx_q.size() - base) < n && guard < 400) begin
            @(posedge clk);
            #1;
            if (toggle) tx_ready = ~tx_ready;
            guard++;
        end
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ((rx_q.size() - base) != n) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, rx_q.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[127-8*i -: 8]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i,
                             rx_q[base+i], exp[127-8*i -: 8]);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (master_key !== '0)  begin errors++; $display("FAIL rst_key: got %h, expected 0", master_key); end
        checks++; if (account !== '0)     begin errors++; $display("FAIL rst_acct: got %h, expected 0", account); end
        checks++; if (password !== '0)    begin errors++; $display("FAIL rst_pwd: got %h, expected 0", password); end
        checks++; if (max_address !== 4'h0) begin errors++; $display("FAIL rst_max: got %h, expected 0", max_address); end
        checks++; if (go !== 1'b0)        begin errors++; $display("FAIL rst_go: got %b, expected 0", go); end
        checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_txv: got %b, expected 0", tx_valid); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b, expected 0", err); end
        checks++; if (rx_ready !== 1'b1)  begin errors++; $display("FAIL rst_rxrdy: got %b, expected 1", rx_ready); end
    endtask

    task automatic test_encrypt_no_key();
        int acc = 0;
        int g0, b0;
        bit ok;
        g0 = go_cnt;
        b0 = rx_q.size();
        send_byte(8'h02, ok);
        if (ok) acc++;
        send_block(128'h0, acc);
        send_block(PWD, acc);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (acc != 33)        begin errors++; $display("FAIL nokey_consumed: got %0d, expected 33", acc); end
        checks++; if (go_cnt != g0)     begin errors++; $display("FAIL nokey_go: got %0d pulses, expected 0", go_cnt - g0); end
        checks++; if (err !== 1'b1)     begin errors++; $display("FAIL nokey_err: got %b, expected 1", err); end
        checks++; if (rx_q.size() != b0) begin errors++; $display("FAIL nokey_tx: got %0d bytes, expected 0", rx_q.size() - b0); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL nokey_idle: got rx_ready %b, expected 1", rx_ready); end
    endtask

    task automatic test_set_key();
        int acc = 0;
        int g0;
        bit ok;
        g0 = go_cnt;
        send_byte(8'h01, ok);
        if (ok) acc++;
        send_block(KEY, acc);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (acc != 17)          begin errors++; $display("FAIL setkey_consumed: got %0d, expected 17", acc); end
        checks++; if (master_key !== KEY) begin errors++; $display("FAIL setkey_value: got %h, expected %h", master_key, KEY); end
        checks++; if (go_cnt != g0)       begin errors++; $display("FAIL setkey_go: got %0d pulses, expected 0", go_cnt - g0); end
        checks++; if (rx_ready !== 1'b1)  begin errors++; $display("FAIL setkey_idle: got rx_ready %b, expected 1", rx_ready); end
    endtask

    // Sends a full ENCRYPT frame; returns right after the final byte handshake.
    task automatic send_encrypt(input logic [127:0] acct, input logic [127:0] pwd);
        int acc = 0;
        bit ok;
        send_byte(8'h02, ok);
        if (ok) acc++;
        send_block(acct, acc);
        send_block(pwd, acc);
        checks++; if (acc != 33) begin errors++; $display("FAIL enc_consumed: got %0d, expected 33", acc); end
    endtask

    task automatic test_encrypt();
        int g0, b0;
        g0 = go_cnt;
        b0 = rx_q.size();
        send_encrypt(128'h0, PWD);
        checks++; if (go !== 1'b1)       begin errors++; $display("FAIL enc_go_latency: got %b, expected 1", go); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL enc_rxrdy_busy: got %b, expected 0", rx_ready); end
        // done during START must be ignored
        done         = 1'b1;
        password_enc = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL enc_done_in_start: got tx_valid %b, expected 0", tx_valid); end
        password_enc = ENC1;
        @(posedge clk);
        #1;
        done = 1'b0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL enc_tx_latency: got %b, expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL enc_first_byte: got %02h, expected 01", tx_data); end
        collect(ENC1, 16, 1'b0, b0, "enc");
        checks++; if (go_cnt != g0 + 1)  begin errors++; $display("FAIL enc_go_count: got %0d pulses, expected 1", go_cnt - g0); end
        checks++; if (account !== 128'h0) begin errors++; $display("FAIL enc_acct: got %h, expected 0", account); end
        checks++; if (password !== PWD)  begin errors++; $display("FAIL enc_pwd: got %h, expected %h", password, PWD); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL enc_back_idle: got rx_ready %b, expected 1", rx_ready); end
    endtask

    task automatic test_tx_stall();
        int b0, s0;
        b0 = rx_q.size();
        s0 = stall_viol;
        send_encrypt(KEY, ENC1);
        tx_ready     = 1'b0;
        @(posedge clk);
        #1;
        done         = 1'b1;
        password_enc = ENC2;
        @(posedge clk);
        #1;
        done = 1'b0;
        collect(ENC2, 16, 1'b1, b0, "stall");
        checks++; if (stall_viol != s0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles, expected 0", stall_viol - s0); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL stall_err: got %b, expected 0", err); end
    endtask

    task automatic test_bad_opcode();
        bit ok;
        send_byte(8'h7F, ok);
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL badop_err: got %b, expected 1", err); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL badop_idle: got rx_ready %b, expected 1", rx_ready); end
        send_byte(8'h03, ok);
        send_byte(8'h0A, ok);
        checks++; if (max_address !== 4'hA) begin errors++; $display("FAIL badop_setmax: got %h, expected a", max_address); end
    endtask

    task automatic test_reset_mid_field();
        int acc = 0;
        int b0, g0;
        bit ok;
        send_byte(8'h02, ok);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h11 * (i + 1), ok);
        end
        checks++; if (account[127:64] !== 64'h1122334455667788) begin errors++; $display("FAIL mid_partial: got %h, expected 1122334455667788", account[127:64]); end
        apply_reset();
        checks++; if (account !== '0)    begin errors++; $display("FAIL mid_rst_acct: got %h, expected 0", account); end
        checks++; if (master_key !== '0) begin errors++; $display("FAIL mid_rst_key: got %h, expected 0", master_key); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err: got %b, expected 0", err); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b, expected 1", rx_ready); end
        // key_valid must have been cleared: a keyless ENCRYPT is rejected
        g0 = go_cnt;
        send_encrypt(128'h5, PWD);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (go_cnt != g0 || err !== 1'b1) begin errors++; $display("FAIL mid_keyvalid_cleared: got go %0d err %b, expected go 0 err 1", go_cnt - g0, err); end
        apply_reset();
        send_byte(8'h01, ok);
        send_block(KEY, acc);
        b0 = rx_q.size();
        send_encrypt(128'h5, PWD);
        checks++; if (go !== 1'b1) begin errors++; $display("FAIL mid_fresh_go: got %b, expected 1", go); end
        @(posedge clk);
        #1;
        done         = 1'b1;
        password_enc = ENC1;
        @(posedge clk);
        #1;
        done = 1'b0;
        collect(ENC1, 16, 1'b0, b0, "fresh");
    endtask

`ifdef PK_DONE_TIMEOUT_EN
    task automatic test_timeout();
        int acc = 0;
        int b0;
        bit ok;
        apply_reset();
        send_byte(8'h01, ok);
        send_block(KEY, acc);
        b0 = rx_q.size();
        send_encrypt(128'h0, PWD);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL to_early: got tx_valid %b, expected 0", tx_valid); end
        collect({8'hEE, 120'h0}, 1, 1'b0, b0, "timeout");
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b, expected 1", err); end
        done         = 1'b1;
        password_enc = ENC1;
        repeat (3) @(posedge clk);
        #1;
        done = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (rx_q.size() != b0 + 1) begin errors++; $display("FAIL to_late_done: got %0d bytes, expected 1", rx_q.size() - b0); end
        checks++; if (rx_ready !== 1'b1)     begin errors++; $display("FAIL to_idle: got rx_ready %b, expected 1", rx_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt_no_key();
        apply_reset();
        test_set_key();
        test_encrypt();
        test_tx_stall();
        test_bad_opcode();
        test_reset_mid_field();
`ifdef PK_DONE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
